// File: rtl/mips150_mem_pkg.sv
// Shared encodings for the DMEM port arbiter and its helpers.
package mips150_mem_pkg;

    // Byte-enable width of the DMEM port (32-bit words).
    localparam int BE_W = 4;

    // Which requester owned the port in a given cycle.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // Arbiter state: normal CPU-priority cycle or a forced DMA cycle.
    typedef enum logic {
        S_CPU      = 1'b0,
        S_DMA_SLOT = 1'b1
    } state_e;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive CPU grants taken while the DMA waits.
// at_limit_o reports the value the counter holds after this cycle's
// update, so the arbiter can schedule the DMA slot on the same edge.
module arb_streak_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear wins over increment; increment saturates at MAX.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (inc_i) begin
            if (count_q < 4'(MAX)) begin
                count_d = count_q + 4'd1;
            end
        end
    end

    assign at_limit_o = (count_d == 4'(MAX));

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single synchronous-read DMEM port between the CPU M-stage
// (fixed priority) and a DMA requester that is guaranteed a forced slot
// after MAX_CPU_STREAK contended CPU grants.
module dmem_port_arbiter
    import mips150_mem_pkg::*;
#(
    parameter int AW             = 12,
    parameter int DW             = 32,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [DW/8-1:0]   cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_stall,
    output logic [DW-1:0]     cpu_rdata,
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic [DW/8-1:0]   dma_we,
    input  logic [AW-1:0]     dma_addr,
    input  logic [DW-1:0]     dma_wdata,
    output logic              dma_rvalid,
    output logic [DW-1:0]     dma_rdata,
    output logic              mem_en,
    output logic [DW/8-1:0]   mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   rd_pend_q, rd_pend_d;
    logic   streak_inc;
    logic   streak_clr;
    logic   streak_at_limit;

    arb_streak_counter #(
        .MAX (MAX_CPU_STREAK)
    ) u_streak (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (streak_clr),
        .inc_i      (streak_inc),
        .at_limit_o (streak_at_limit)
    );

    // Grant decision, port mux and next state; everything is held idle while in reset.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cpu_stall  = 1'b0;
        dma_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = '0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        streak_inc = 1'b0;
        streak_clr = 1'b0;
        if (rst) begin
            case (state_q)
                S_CPU: begin
                    if (cpu_req) begin
                        mem_en  = 1'b1;
                        mem_we  = cpu_we;
                        owner_d = OWN_CPU;
                        if (dma_valid) begin
                            streak_inc = 1'b1;
                            if (streak_at_limit) begin
                                state_d = S_DMA_SLOT;
                            end
                        end else begin
                            streak_clr = 1'b1;
                        end
                    end else if (dma_valid) begin
                        dma_ready  = 1'b1;
                        mem_en     = 1'b1;
                        mem_we     = dma_we;
                        mem_addr   = dma_addr;
                        mem_wdata  = dma_wdata;
                        owner_d    = OWN_DMA;
                        streak_clr = 1'b1;
                    end else begin
                        streak_clr = 1'b1;
                    end
                end
                S_DMA_SLOT: begin
                    // A withdrawn request leaves the slot idle and the CPU unstalled.
                    dma_ready  = 1'b1;
                    mem_addr   = dma_addr;
                    mem_wdata  = dma_wdata;
                    streak_clr = 1'b1;
                    state_d    = S_CPU;
                    if (dma_valid) begin
                        mem_en    = 1'b1;
                        mem_we    = dma_we;
                        owner_d   = OWN_DMA;
                        cpu_stall = cpu_req;
                    end
                end
                default: begin
                    state_d = S_CPU;
                end
            endcase
        end
    end

    assign rd_pend_d = mem_en & (mem_we == '0);

    // Read data follows the port one cycle later; only the DMA gets a valid strobe.
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign dma_rvalid = rst & rd_pend_q & (owner_q == OWN_DMA);

    // State, owner and read-pending registers; reset drops any in-flight return.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_CPU;
            owner_q   <= OWN_CPU;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios with
// literal expectations plus a per-cycle comparison against a grant model.
module tb_dmem_port_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          dma_valid;
    logic          dma_ready;
    logic [3:0]    dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .AW             (AW),
        .DW             (DW),
        .MAX_CPU_STREAK (MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // DMEM driven by the DUT's port; ref_mem is the model's own copy.
    logic [DW-1:0] dmem    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            dmem[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        dmem[12'h010]    = 32'hDEADBEEF;
        ref_mem[12'h010] = 32'hDEADBEEF;
        mem_rdata        = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= dmem[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: count of consecutive contended CPU grants, a pending forced slot
    // flag, and the data the last read should return.
    int            m_run = 0, n_run = 0;
    bit            m_slot = 0, n_slot = 0;
    bit            m_prev_dma_rd = 0, n_prev_dma_rd = 0;
    bit            m_prev_cpu_rd = 0, n_prev_cpu_rd = 0;
    logic [DW-1:0] m_prev_data = '0, n_prev_data = '0;

    always @(negedge clk) begin
        bit            g_cpu, g_dma, e_ready, e_stall, e_rvalid, e_en;
        logic [3:0]    e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        g_cpu = 0; g_dma = 0; e_ready = 0; e_stall = 0; e_rvalid = 0;
        n_run = 0; n_slot = 0;
        if (rst) begin
            e_rvalid = m_prev_dma_rd;
            if (m_slot) begin
                e_ready = 1;
                g_dma   = dma_valid;
                e_stall = cpu_req && dma_valid;
            end else if (cpu_req) begin
                g_cpu = 1;
                if (dma_valid) begin
                    n_run  = (m_run + 1 > MAX) ? MAX : m_run + 1;
                    n_slot = (n_run == MAX);
                end
            end else begin
                g_dma   = dma_valid;
                e_ready = dma_valid;
            end
        end
        e_en    = g_cpu || g_dma;
        e_we    = g_cpu ? cpu_we : (g_dma ? dma_we : 4'h0);
        e_addr  = g_cpu ? cpu_addr : dma_addr;
        e_wdata = g_cpu ? cpu_wdata : dma_wdata;

        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("dma_ready", 32'(dma_ready), 32'(e_ready));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(e_rvalid));
        if (e_en) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we != 4'h0) chk("mem_wdata", mem_wdata, e_wdata);
        end
        if (e_rvalid) chk("dma_rdata", dma_rdata, m_prev_data);
        if (rst && m_prev_cpu_rd) chk("cpu_rdata", cpu_rdata, m_prev_data);

        n_prev_dma_rd = g_dma && (dma_we == 4'h0);
        n_prev_cpu_rd = g_cpu && (cpu_we == 4'h0);
        n_prev_data   = m_prev_data;
        if (e_en) begin
            if (e_we == 4'h0) n_prev_data = ref_mem[e_addr];
            for (int b = 0; b < 4; b++) begin
                if (e_we[b]) ref_mem[e_addr][8*b +: 8] = e_wdata[8*b +: 8];
            end
        end
    end

    always @(posedge clk) begin
        m_run         <= n_run;
        m_slot        <= n_slot;
        m_prev_dma_rd <= n_prev_dma_rd;
        m_prev_cpu_rd <= n_prev_cpu_rd;
        m_prev_data   <= n_prev_data;
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 4'h0; dma_valid = 0; dma_we = 4'h0;
    endtask

    initial begin
        rst = 0; cpu_req = 1; cpu_we = 4'h0; cpu_addr = 12'h100; cpu_wdata = 32'h0;
        dma_valid = 1; dma_we = 4'h0; dma_addr = 12'h010; dma_wdata = 32'h0;

        // Reset with both requesters active: port stays idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_dma_ready", 32'(dma_ready), 32'd0);
            chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
            adv();
        end
        rst = 1;

        // Continuous contention: four CPU grants then one forced DMA slot.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("cont_stall_%0d", i), 32'(cpu_stall), 32'((i % 5) == 4));
            chk($sformatf("cont_ready_%0d", i), 32'(dma_ready), 32'((i % 5) == 4));
            chk($sformatf("cont_en_%0d", i), 32'(mem_en), 32'd1);
            adv();
        end

        // DMA-only read of 0x010.
        idle(); adv();
        dma_valid = 1; dma_we = 4'h0; dma_addr = 12'h010;
        @(negedge clk);
        chk("dma_only_ready", 32'(dma_ready), 32'd1);
        adv();
        idle();
        @(negedge clk);
        chk("dma_only_rvalid", 32'(dma_rvalid), 32'd1);
        chk("dma_only_rdata", dma_rdata, 32'hDEADBEEF);
        adv();

        // CPU half-word store, then DMA read of the same word.
        cpu_req = 1; cpu_we = 4'b0011; cpu_addr = 12'h020; cpu_wdata = 32'h0000ABCD;
        @(negedge clk);
        chk("store_mem_we", 32'(mem_we), 32'h3);
        chk("store_mem_addr", 32'(mem_addr), 32'h020);
        adv();
        idle(); dma_valid = 1; dma_addr = 12'h020;
        @(negedge clk);
        chk("store_rd_ready", 32'(dma_ready), 32'd1);
        adv();
        idle();
        @(negedge clk);
        chk("store_rd_low", 32'(dma_rdata[15:0]), 32'h0000ABCD);
        adv();

        // DMA withdraws during its forced slot.
        cpu_req = 1; cpu_addr = 12'h030; dma_valid = 1; dma_addr = 12'h010;
        for (int i = 0; i < 4; i++) adv();
        dma_valid = 0;
        @(negedge clk);
        chk("wd_mem_en", 32'(mem_en), 32'd0);
        chk("wd_stall", 32'(cpu_stall), 32'd0);
        adv();
        @(negedge clk);
        chk("wd_rvalid", 32'(dma_rvalid), 32'd0);
        chk("wd_cpu_grant", 32'(mem_en), 32'd1);
        chk("wd_no_stall", 32'(cpu_stall), 32'd0);
        adv();

        // Reset right after a DMA read grant drops the return.
        idle(); dma_valid = 1; dma_addr = 12'h010;
        @(negedge clk);
        chk("rr_ready", 32'(dma_ready), 32'd1);
        adv();
        rst = 0; dma_valid = 0;
        @(negedge clk);
        chk("rr_rvalid", 32'(dma_rvalid), 32'd0);
        adv();
        rst = 1; cpu_req = 1; dma_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rr_stall_%0d", i), 32'(cpu_stall), 32'(i == 4));
            adv();
        end

        // Mixed traffic over a small address window, checked by the model.
        for (int i = 0; i < 300; i++) begin
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            cpu_addr  = 12'($urandom_range(0, 7));
            cpu_wdata = $urandom;
            dma_valid = 1'($urandom_range(0, 3) != 0);
            dma_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            dma_addr  = 12'($urandom_range(0, 7));
            dma_wdata = $urandom;
            adv();
        end

        idle(); adv(); adv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
